// File: rtl/add_round_key_stage.sv
// AES-128 round-key addition stage.
// Holds the expanded round keys (written serially by the key schedule) and
// XORs each accepted state with the selected round key into a 1-deep,
// back-pressurable output register.
module add_round_key_stage #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_wr_en,
  input  logic [IDX_W-1:0]   key_wr_idx,
  input  logic [127:0]       key_wr_data,
  output logic               keys_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       data_in,
  input  logic [IDX_W-1:0]   round_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       data_out,
  output logic [IDX_W-1:0]   round_out,
  output logic               last_round,
  output logic               err
);

  localparam int               NUM_KEYS = NUM_ROUNDS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  logic [127:0]        key_mem [NUM_KEYS];
  logic [NUM_KEYS-1:0] loaded;
  logic                last_q;

  logic                accept;
  logic                key_wr_ok;
  logic                rd_bad;
  logic                sel_loaded;
  logic [127:0]        key_sel;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign key_wr_ok  = key_wr_en && (key_wr_idx <= LAST_IDX);
  assign rd_bad     = round_in > LAST_IDX;
  assign last_round = last_q && out_valid;

  // Select the round key for the incoming state, forwarding a same-cycle key write.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    key_sel    = '0;
    sel_loaded = 1'b0;
    if (!rd_bad) begin
      if (key_wr_en && (key_wr_idx == round_in)) begin
        key_sel    = key_wr_data;
        sel_loaded = 1'b1;
      end else begin
        key_sel    = key_mem[round_in];
        sel_loaded = loaded[round_in];
      end
    end
  end

  // Key store, error flag and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the key array is cleared on reset so stale keys never leak into a
      // new session; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_mem[i] <= '0;
      end
      loaded     <= '0;
      keys_ready <= 1'b0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      round_out  <= '0;
      last_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (key_wr_ok) begin
        key_mem[key_wr_idx] <= key_wr_data;
        loaded[key_wr_idx]  <= 1'b1;
      end

      // Registered AND: rises one cycle after the last missing entry lands.
      keys_ready <= &loaded;

      if ((key_wr_en && !key_wr_ok) || (accept && !sel_loaded)) begin
        err <= 1'b1;
      end

      if (accept) begin
        data_out  <= data_in ^ key_sel;
        round_out <= round_in;
        last_q    <= (round_in == LAST_IDX);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Round-key addition stage directly downstream of mix_column in the iterative AES-128 encryption datapath.
- Holds an on-chip store of the 11 expanded round keys, loaded serially by the key schedule.
- Accepts a 128-bit state plus round index through a valid/ready handshake and XORs the state with the selected round key.
- Presents the result on a registered, back-pressurable output.

Parameters:
- NUM_ROUNDS, 10: number of AES rounds; the key store holds NUM_ROUNDS+1 entries (indices 0..NUM_ROUNDS).
- IDX_W, 4: width of round/key index fields; must satisfy 2^IDX_W > NUM_ROUNDS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- key_wr_en  input  1  key store write strobe
- key_wr_idx  input  IDX_W  key store write index
- key_wr_data  input  128  round key; bits [127:120] are byte 0
- keys_ready  output  1  high when every entry 0..NUM_ROUNDS has been written since reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  stage can accept a state this cycle
- data_in  input  128  state from mix_column; column-major, [127:120] = s(0,0)
- round_in  input  IDX_W  round-key index to apply
- out_valid  output  1  data_out valid
- out_ready  input  1  downstream accepts
- data_out  output  128  data_in XOR key[round_in]
- round_out  output  IDX_W  round index travelling with data_out
- last_round  output  1  round_out == NUM_ROUNDS, qualified by out_valid
- err  output  1  sticky error flag

Behaviour:
- Reset, synchronous, takes priority over all other activity:
  - out_valid=0, data_out=0, round_out=0, last_round=0, err=0, keys_ready=0.
  - All key entries cleared to 0 and their loaded bits cleared.
  - A transfer in flight is discarded.
- Key store:
  - On key_wr_en with key_wr_idx <= NUM_ROUNDS, write the entry and set its loaded bit.
  - On key_wr_en with key_wr_idx > NUM_ROUNDS, drop the write and set err.
  - keys_ready is the registered AND of all loaded bits; it rises the cycle after the final missing entry is written.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; 1-deep output register).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - No combinational path from in_valid to out_valid.
- Accept cycle, registered next edge (latency 1):
  - data_out <= data_in ^ key[round_in]
  - round_out <= round_in
  - last_round <= (round_in == NUM_ROUNDS)
  - out_valid <= 1
- Output register control:
  - If out_valid && !out_ready, hold data_out, round_out and last_round stable; in_ready=0.
  - If out_valid && out_ready && no accept, out_valid <= 0 (data_out holds its last value).
  - Simultaneous output transfer and accept: output register reloads with the new result and out_valid stays 1. Full throughput is one state per cycle.
- Write/read collision: key_wr_en with key_wr_idx == round_in in an accept cycle bypasses, so the new key_wr_data is used.
- Error and degenerate cases:
  - Accept with round_in > NUM_ROUNDS: state is passed through unmodified (XOR with zero) and err is set.
  - Accept with key[round_in] not yet loaded: XOR with the stored value (0 after reset) and err is set.
  - err clears only on rst.
- Arithmetic: pure bitwise 128-bit XOR, no carries; byte ordering is preserved bit-for-bit.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=1 for 5 cycles, in_valid=0.
  - Required: all outputs 0 and in_ready=1 from the first post-reset edge onward.
- Round 0, FIPS-197 Appendix B:
  - Stimulus: load key[0]=2b7e151628aed2a6abf7158809cf4f3c; apply data_in=3243f6a8885a308d313198a2e0370734, round_in=0.
  - Required: one cycle later data_out=193de3bea0f4e22b9ac68d2ae9f84808, round_out=0, last_round=0.
- Round 1:
  - Stimulus: load key[1]=a0fafe1788542cb123a339392a6c7605; apply data_in=046681e5e0cb199a48f8d37a2806264c, round_in=1.
  - Required: data_out=a49c7ff2689f352b6b5bea43026a5049.
- Back-pressure:
  - Stimulus: stream 3 states with out_ready=0 for 4 cycles, then 1.
  - Required: first result held stable, in_ready=0 while stalled; all 3 results emitted in order with no loss or duplication, then back-to-back at 1 per cycle.
- Bypass:
  - Stimulus: same cycle as an accept, key_wr_en=1 with key_wr_idx=round_in=10 and key_wr_data=ffff…ff; data_in=0.
  - Required: data_out=ffff…ff and last_round=1.
- Errors and keys_ready:
  - Stimulus: write idx 11; accept round_in=12; load all 11 keys; assert rst mid-stream.
  - Required: err=1 after the first bad event; keys_ready rises exactly one cycle after the 11th write; rst clears err, keys_ready and out_valid on the next edge.
